// File: rtl/led_pio_rmw_arbiter.sv
// led_pio_rmw_arbiter: Avalon-MM master owning the LED PIO data register.
// Two requesters share it; each transaction is an atomic read-modify-write
// that merges the requester's masked bits into the current LED value.
module led_pio_rmw_arbiter #(
  parameter int unsigned LED_WIDTH = 8,
  parameter logic [1:0]  PIO_ADDR  = 2'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [LED_WIDTH-1:0] mask0,
  input  logic [LED_WIDTH-1:0] value0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [LED_WIDTH-1:0] mask1,
  input  logic [LED_WIDTH-1:0] value1,
  output logic                 ack1,
  output logic [1:0]           pio_address,
  output logic                 pio_chipselect,
  output logic                 pio_write_n,
  output logic [31:0]          pio_writedata,
  input  logic [31:0]          pio_readdata,
  output logic                 busy,
  output logic                 grant_id
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic [LED_WIDTH-1:0] mask_q, mask_d;
  logic [LED_WIDTH-1:0] value_q, value_d;
  logic [LED_WIDTH-1:0] wdata_q, wdata_d;
  logic                 cs_q, cs_d;
  logic                 wn_q, wn_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 busy_q, busy_d;
  logic [1:0]           address_q;

  // Only the LED field of the read bus is merged; the upper bits are ignored.
  logic unused_rd;
  assign unused_rd = ^pio_readdata[31:LED_WIDTH];

  // Next-state logic, arbitration, merge, and next values of every registered output.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    grant_d = grant_q;
    mask_d  = mask_q;
    value_d = value_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Round-robin on contention: serve whoever was not served last.
          grant_d = (req0 && req1) ? ~grant_q : req1;
          mask_d  = grant_d ? mask1  : mask0;
          value_d = grant_d ? value1 : value0;
          if (&mask_d) begin
            // Every bit is overwritten, so the read is pointless.
            state_d = WRITE;
            wdata_d = value_d;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        // Readback is captured at the end of READ straight into the write data.
        wdata_d = (pio_readdata[LED_WIDTH-1:0] & ~mask_q) | (value_q & mask_q);
        state_d = WRITE;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs follow the state they will be presented in, so they can be registered.
    cs_d   = (state_d == READ) || (state_d == WRITE);
    wn_d   = (state_d != WRITE);
    busy_d = (state_d != IDLE);
    ack0_d = (state_d == DONE) && !grant_d;
    ack1_d = (state_d == DONE) &&  grant_d;
  end

  // State and registered outputs; synchronous reset returns everything to idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b1;
      // NOTE: the latched request is reset too; it is only a few flops and keeps simulation X-free.
      mask_q    <= '0;
      value_q   <= '0;
      wdata_q   <= '0;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      address_q <= PIO_ADDR;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      wdata_q   <= wdata_d;
      cs_q      <= cs_d;
      wn_q      <= wn_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
      address_q <= PIO_ADDR;
    end
  end

  // NOTE: the strobes are qualified by reset so a reset arriving during WRITE aborts the bus write
  // in that same cycle; otherwise the PIO, which has its own reset, would still latch the data.
  assign pio_chipselect = cs_q & ~reset;
  assign pio_write_n    = wn_q | reset;
  assign pio_address    = address_q;
  assign pio_writedata  = {{(32-LED_WIDTH){1'b0}}, wdata_q};
  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;

endmodule
